// File: rtl/forward_hazard_unit_pkg.sv
// =============================================================================
// forward_hazard_unit_pkg : shared core constants (register width, mux selects)
// Revision: 1.0
// =============================================================================
`default_nettype none

package forward_hazard_unit_pkg;

  localparam int         REG_AW  = 5;
  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

endpackage

`default_nettype wire

// File: rtl/forward_hazard_unit_fwd_select.sv
// =============================================================================
// fwd_select : picks the EX operand source for one source register
// Revision: 1.0
// =============================================================================
`default_nettype none

module fwd_select
  import forward_hazard_unit_pkg::*;
#(
  parameter int         REG_AW  = forward_hazard_unit_pkg::REG_AW,
  parameter logic [1:0] SEL_RF  = forward_hazard_unit_pkg::SEL_RF,
  parameter logic [1:0] SEL_WB  = forward_hazard_unit_pkg::SEL_WB,
  parameter logic [1:0] SEL_MEM = forward_hazard_unit_pkg::SEL_MEM
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_reg_write,
  output logic [1:0]        o_sel
);

  // The younger producer (MEM) wins over WB; x0 is never a source.
  always_comb begin
    o_sel = SEL_RF;
    if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_rs)) begin
      o_sel = SEL_MEM;
    end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_rs)) begin
      o_sel = SEL_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/forward_hazard_unit.sv
// =============================================================================
// forward_hazard_unit : EX operand forwarding selects and load-use stall
// Revision: 1.0
// =============================================================================
`default_nettype none

module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int         REG_AW  = forward_hazard_unit_pkg::REG_AW,
  parameter logic [1:0] SEL_RF  = forward_hazard_unit_pkg::SEL_RF,
  parameter logic [1:0] SEL_WB  = forward_hazard_unit_pkg::SEL_WB,
  parameter logic [1:0] SEL_MEM = forward_hazard_unit_pkg::SEL_MEM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              freeze,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall
);

  logic [REG_AW-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic              r_ex_reg_write, r_ex_mem_read;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_reg_write, r_mem_mem_read;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_reg_write;

  logic w_stall;
  logic w_ex_bubble;
  logic w_unused_mem_read;

  assign w_stall = id_valid && !flush && r_ex_mem_read && (r_ex_rd != '0) &&
                   ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
  assign w_ex_bubble       = w_stall || flush || !id_valid;
  assign stall             = w_stall;
  // MEM.mem_read is tracked for pipeline completeness but nothing consumes it.
  assign w_unused_mem_read = r_mem_mem_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_ex_rd         <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_mem_rd        <= '0;
      r_mem_reg_write <= 1'b0;
      r_mem_mem_read  <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_reg_write  <= 1'b0;
    end else if (!freeze) begin
      r_wb_rd         <= r_mem_rd;
      r_wb_reg_write  <= r_mem_reg_write;
      r_mem_rd        <= r_ex_rd;
      r_mem_reg_write <= r_ex_reg_write;
      r_mem_mem_read  <= r_ex_mem_read;
      if (w_ex_bubble) begin
        r_ex_rs1       <= '0;
        r_ex_rs2       <= '0;
        r_ex_rd        <= '0;
        r_ex_reg_write <= 1'b0;
        r_ex_mem_read  <= 1'b0;
      end else begin
        r_ex_rs1       <= id_rs1;
        r_ex_rs2       <= id_rs2;
        r_ex_rd        <= id_rd;
        r_ex_reg_write <= id_reg_write;
        r_ex_mem_read  <= id_mem_read;
      end
    end
  end

  fwd_select #(
    .REG_AW (REG_AW),
    .SEL_RF (SEL_RF),
    .SEL_WB (SEL_WB),
    .SEL_MEM(SEL_MEM)
  ) u_fwd_a (
    .i_rs           (r_ex_rs1),
    .i_mem_rd       (r_mem_rd),
    .i_mem_reg_write(r_mem_reg_write),
    .i_wb_rd        (r_wb_rd),
    .i_wb_reg_write (r_wb_reg_write),
    .o_sel          (fwd_a_sel)
  );

  fwd_select #(
    .REG_AW (REG_AW),
    .SEL_RF (SEL_RF),
    .SEL_WB (SEL_WB),
    .SEL_MEM(SEL_MEM)
  ) u_fwd_b (
    .i_rs           (r_ex_rs2),
    .i_mem_rd       (r_mem_rd),
    .i_mem_reg_write(r_mem_reg_write),
    .i_wb_rd        (r_wb_rd),
    .i_wb_reg_write (r_wb_reg_write),
    .o_sel          (fwd_b_sel)
  );

endmodule

`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
// =============================================================================
// tb_forward_hazard_unit : scoreboard bench for forward_hazard_unit
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic       flush = 1'b0, freeze = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       s;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  forward_hazard_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .freeze      (freeze),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall)
  );

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if ((fwd_a_sel !== e.a) || (fwd_b_sel !== e.b) || (stall !== e.s)) begin
        n_fail++;
        $display("FAIL %s: got a=%0d b=%0d stall=%0d, expected a=%0d b=%0d stall=%0d",
                 e.nm, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.s);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic fl, input logic fz,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic mr,
                      input logic [1:0] ea, input logic [1:0] eb, input logic es,
                      input string nm);
    rst_n        = r;
    id_valid     = v;
    flush        = fl;
    freeze       = fz;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    q.push_back('{a: ea, b: eb, s: es, nm: nm});
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic rw, input logic mr,
                     input logic [1:0] ea, input logic [1:0] eb, input logic es,
                     input string nm);
    step(1'b1, 1'b1, 1'b0, 1'b0, rs1, rs2, rd, rw, mr, ea, eb, es, nm);
  endtask

  task automatic nop(input logic [1:0] ea, input logic [1:0] eb, input logic es,
                     input string nm);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ea, eb, es, nm);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 5, 5, 6, 1, 1, 0, 0, 0, "reset_hold");
    nop(0, 0, 0, "post_reset");
    // add x5 ; add x6,x5,x5
    ins(1, 2, 5, 1, 0, 0, 0, 0, "s1_add5");
    ins(5, 5, 6, 1, 0, 0, 0, 0, "s1_use_id");
    nop(2, 2, 0, "s1_raw_mem");
    nop(0, 0, 0, "s1_drain");
    // add x5 ; nop ; sub x7,x5,x1
    ins(3, 4, 5, 1, 0, 0, 0, 0, "s2_add5");
    nop(0, 0, 0, "s2_gap");
    ins(5, 1, 7, 1, 0, 0, 0, 0, "s2_sub");
    nop(1, 0, 0, "s2_raw_wb");
    // add x5 ; addi x5,x5 ; use x5
    ins(1, 2, 5, 1, 0, 0, 0, 0, "s3_add5");
    ins(5, 0, 5, 1, 0, 0, 0, 0, "s3_addi5");
    ins(5, 5, 10, 1, 0, 2, 0, 0, "s3_addi_fwd");
    nop(2, 2, 0, "s3_mem_priority");
    nop(0, 0, 0, "s3_drain");
    // lw x8 ; add x9,x8,x2
    ins(3, 0, 8, 1, 1, 0, 0, 0, "s4_lw8");
    ins(8, 2, 9, 1, 0, 0, 0, 1, "s4_stall");
    ins(8, 2, 9, 1, 0, 0, 0, 0, "s4_one_cycle");
    nop(1, 0, 0, "s4_wb_fwd");
    nop(0, 0, 0, "s4_drain");
    // writes to x0, lw x0 then use of x0
    ins(1, 2, 0, 1, 0, 0, 0, 0, "s5_add_x0");
    ins(1, 0, 0, 1, 1, 0, 0, 0, "s5_lw_x0");
    ins(0, 0, 11, 1, 0, 0, 0, 0, "s5_x0_no_stall");
    nop(0, 0, 0, "s5_x0_no_fwd");
    nop(0, 0, 0, "s5_drain");
    // flush with a pending load-use
    ins(1, 0, 12, 1, 1, 0, 0, 0, "s6_lw12");
    step(1'b1, 1'b1, 1'b1, 1'b0, 12, 12, 13, 1, 0, 0, 0, 0, "s6_flush");
    ins(3, 12, 14, 1, 0, 0, 0, 0, "s6_flush_bubble");
    nop(0, 1, 0, "s6_wb_fwd");
    // freeze for three cycles holds the selects
    ins(1, 2, 15, 1, 0, 0, 0, 0, "s7_add15");
    ins(15, 0, 16, 1, 0, 0, 0, 0, "s7_add16");
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 2, 0, 0, "s7_frz0");
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 2, 0, 0, "s7_frz1");
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 2, 0, 0, "s7_frz2");
    nop(2, 0, 0, "s7_frz_release");
    nop(0, 0, 0, "s7_drain");
    // reset pulse in the middle of a frozen load-use stall
    ins(1, 0, 17, 1, 1, 0, 0, 0, "s8_lw17");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2, 17, 18, 1, 0, 0, 0, 1, "s8_stall_frz");
    step(1'b0, 1'b1, 1'b0, 1'b1, 2, 17, 18, 1, 0, 0, 0, 0, "s8_rst_async");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2, 17, 18, 1, 0, 0, 0, 0, "s8_no_residual");
    nop(0, 0, 0, "s8_discard");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- REG_AW, 5, register-address width
- SEL_RF, 2'd0, operand select: register-file value
- SEL_WB, 2'd1, operand select: MEM/WB write-back value
- SEL_MEM, 2'd2, operand select: EX/MEM ALU result
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge
- rst_n, in, 1, asynchronous, active-low reset
- id_valid, in, 1, the ID-stage instruction is real (not a bubble)
- id_rs1, in, REG_AW, ID-stage source register 1
- id_rs2, in, REG_AW, ID-stage source register 2
- id_rd, in, REG_AW, ID-stage destination register
- id_reg_write, in, 1, the ID-stage instruction writes rd
- id_mem_read, in, 1, the ID-stage instruction is a load
- flush, in, 1, kill the ID-stage instruction (taken branch/jump)
- freeze, in, 1, global pipeline hold (memory wait)
- fwd_a_sel, out, 2, select for the EX operand-A 3-to-1 mux
- fwd_b_sel, out, 2, select for the EX operand-B 3-to-1 mux
- stall, out, 1, hold PC and IF/ID; the ID instruction enters EX as a bubble

Function
REQ-003 The unit SHALL keep shadow registers for three stages:
- EX: rs1, rs2, rd, reg_write, mem_read
- MEM: rd, reg_write, mem_read
- WB: rd, reg_write
REQ-004 On each clock edge with freeze=0:
- WB SHALL load MEM, and MEM SHALL load EX.
- EX SHALL load the ID inputs.
- EX SHALL instead load a bubble (reg_write=0, mem_read=0, all addresses 0) when stall=1, flush=1 or id_valid=0.
REQ-005 With freeze=1, all shadow registers SHALL hold; freeze SHALL take precedence over flush and stall, and the flush source holds flush until freeze deasserts.
REQ-006 fwd_a_sel SHALL be combinational from the shadow registers:
- SEL_MEM if MEM.reg_write, MEM.rd!=0 and MEM.rd==EX.rs1;
- else SEL_WB if WB.reg_write, WB.rd!=0 and WB.rd==EX.rs1;
- else SEL_RF.
REQ-007 fwd_b_sel SHALL follow the same rule as REQ-006, using EX.rs2 in place of EX.rs1.
REQ-008 The encoding 2'd3 SHALL never be driven.
REQ-009 stall SHALL be combinational: 1 when id_valid, EX.mem_read, EX.rd!=0, and EX.rd equals id_rs1 or id_rs2; otherwise 0.
REQ-010 stall SHALL be forced to 0 when flush=1.
REQ-011 A load-use hazard SHALL cost exactly one stall cycle; the dependent instruction then receives SEL_WB from the load.
REQ-012 Register x0 SHALL never be a forwarding source and SHALL never cause a stall.
REQ-013 Same-cycle ID write-back to the register file is resolved by the register file being write-first; no ID-stage forwarding is provided.

Reset
REQ-014 rst_n=0 SHALL asynchronously clear all shadow registers to bubble state.
REQ-015 While rst_n=0, and after release until new state is clocked in, the outputs SHALL be fwd_a_sel=SEL_RF, fwd_b_sel=SEL_RF, stall=0.
REQ-016 Reset asserted mid-stall or mid-freeze SHALL discard all in-flight state, with no residual stall.

Structure
REQ-017 SEL_RF, SEL_WB, SEL_MEM and REG_AW SHALL be defined in the shared core constants package; the datapath 3-to-1 mux decoder uses the same constants.
REQ-018 The select logic SHALL be one sub-module, fwd_select, instantiated twice (operand A and operand B), taking {rs, MEM.rd, MEM.reg_write, WB.rd, WB.reg_write} and returning a 2-bit select.

Verification
REQ-019 The bench SHALL cover these scenarios:
- add x5,.. then add x6,x5,x5 -> next cycle fwd_a_sel=fwd_b_sel=2'd2, stall=0.
- add x5 ; nop ; sub x7,x5,x1 -> fwd_a_sel=2'd1, fwd_b_sel=2'd0.
- add x5 then addi x5 then use x5 -> 2'd2 (MEM priority over WB).
- lw x8 then add x9,x8,x2 -> stall=1 for exactly 1 cycle, then fwd_a_sel=2'd1.
- writes to x0, and lw x0 followed by a use of x0 -> selects remain 2'd0, stall=0.
- flush=1 with a load-use pending -> stall=0 and the EX bubble gives selects 2'd0.
- freeze=1 for 3 cycles -> selects held.
- rst_n pulse mid-stall -> all outputs 0 asynchronously.
